// File: rtl/nrs_pkg.sv
// Shared constants and types for the NRS ping-pong bit store.
package nrs_pkg;

   localparam int NRS_DEPTH   = 16;
   localparam int BITS_PER_RE = 2;
   // Offsets of the real and imaginary bits within one stored QPSK pair.
   localparam int RE_REAL     = 0;
   localparam int RE_IMAG     = 1;

   // Number of complete sequences currently held in the two banks.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   // Occupancy is fully determined by the two full flags.
   function automatic occ_e occ_from_full(input logic [1:0] full);
      unique case (full)
         2'b00:   return OCC_EMPTY;
         2'b11:   return OCC_TWO;
         default: return OCC_ONE;
      endcase
   endfunction

endpackage

// File: rtl/nrs_bank.sv
// One DEPTH-bit bank: serial single-bit write port, synchronous clear, and
// N_RD combinational QPSK pair reads (address LSB ignored).
module nrs_bank
   import nrs_pkg::*;
#(
   parameter int DEPTH = NRS_DEPTH,
   parameter int LINES = $clog2(DEPTH),
   parameter int N_RD  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [LINES-1:0]      wr_addr,
   input  logic                  wr_bit,
   input  logic                  clr,
   input  logic [N_RD*LINES-1:0] rd_addr,
   output logic [N_RD-1:0]       rd_r,
   output logic [N_RD-1:0]       rd_i
);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [LINES-1:0] a_even, idx_r, idx_i;

   // Next bank contents: clear wins over a write.
   always_comb begin
      mem_d = mem_q;
      if (clr) begin
         mem_d = '0;
      end else if (we) begin
         mem_d[wr_addr] = wr_bit;
      end
   end

   // Bank storage.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   // Pair read per port: the even address holds the real bit, odd the imaginary.
   always_comb begin
      a_even = '0;
      idx_r  = '0;
      idx_i  = '0;
      rd_r   = '0;
      rd_i   = '0;
      for (int k = 0; k < N_RD; k++) begin
         a_even  = rd_addr[k*LINES +: LINES] & ~LINES'(1);
         idx_r   = a_even | LINES'(RE_REAL);
         idx_i   = a_even | LINES'(RE_IMAG);
         rd_r[k] = mem_q[idx_r];
         rd_i[k] = mem_q[idx_i];
      end
   end

endmodule

// File: rtl/nrs_pingpong_buf.sv
// Ping-pong store for NRS Gold bits: the generator fills one bank serially
// while N_RD registered read ports consume QPSK pairs from the other bank.
//
// Handshake: a write is accepted in a cycle where wr_en=1, wr_ready=1 and
// frame_start=0; a sequence is readable while bank_valid=1 and stays readable
// until rd_release is sampled with bank_valid=1. wr_en with wr_ready=0 drops
// the bit and sets the sticky overflow flag.
module nrs_pingpong_buf
   import nrs_pkg::*;
#(
   parameter int DEPTH = NRS_DEPTH,
   parameter int LINES = $clog2(DEPTH),
   parameter int N_RD  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  c_n,
   input  logic                  frame_start,
   output logic                  wr_ready,
   output logic                  overflow,
   input  logic [N_RD-1:0]       rd_en,
   input  logic [N_RD*LINES-1:0] rd_addr,
   input  logic                  rd_release,
   output logic                  bank_valid,
   output logic [N_RD-1:0]       nrs_r,
   output logic [N_RD-1:0]       nrs_i,
   output logic [N_RD-1:0]       rd_vld,
   output logic [1:0]            occ_dbg
);

   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [LINES-1:0] wr_ptr_q, wr_ptr_d;
   logic             overflow_q, overflow_d;
   logic [N_RD-1:0]  nrs_r_q, nrs_r_d;
   logic [N_RD-1:0]  nrs_i_q, nrs_i_d;
   logic [N_RD-1:0]  rd_vld_q, rd_vld_d;

   logic             wr_acc, fill_done, rel_acc;
   logic [1:0]       bank_we, bank_clr;
   logic [N_RD-1:0]  bank_r [2];
   logic [N_RD-1:0]  bank_i [2];

   assign wr_ready   = !full_q[wr_bank_q];
   assign bank_valid = full_q[rd_bank_q];
   assign overflow   = overflow_q;
   assign nrs_r      = nrs_r_q;
   assign nrs_i      = nrs_i_q;
   assign rd_vld     = rd_vld_q;
   assign occ_dbg    = occ_from_full(full_q);

   for (genvar b = 0; b < 2; b++) begin : g_bank
      nrs_bank #(
         .DEPTH(DEPTH),
         .LINES(LINES),
         .N_RD (N_RD)
      ) u_bank (
         .clk    (clk),
         .rst    (rst),
         .we     (bank_we[b]),
         .wr_addr(wr_ptr_q),
         .wr_bit (c_n),
         .clr    (bank_clr[b]),
         .rd_addr(rd_addr),
         .rd_r   (bank_r[b]),
         .rd_i   (bank_i[b])
      );
   end

   // Write/fill/release control and occupancy (full flags) next state.
   always_comb begin
      wr_acc     = wr_en && wr_ready && !frame_start;
      fill_done  = wr_acc && (wr_ptr_q == LINES'(DEPTH - 1));
      rel_acc    = rd_release && bank_valid;
      bank_we    = '0;
      bank_clr   = '0;
      full_d     = full_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = overflow_q;

      bank_we[wr_bank_q] = wr_acc;
      // A partial fill is abandoned; scrub it unless that bank holds a sequence.
      bank_clr[wr_bank_q] = frame_start && !full_q[wr_bank_q];

      if (frame_start) begin
         wr_ptr_d   = '0;
         overflow_d = 1'b0;
      end else if (wr_en && !wr_ready) begin
         overflow_d = 1'b1;
      end else if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + LINES'(1);
      end

      // Release and fill completion never address the same bank, so both apply.
      if (rel_acc) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end
      if (fill_done) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = !wr_bank_q;
      end
   end

   // Read output registers: data sampled from the pre-release bank.
   always_comb begin
      nrs_r_d  = nrs_r_q;
      nrs_i_d  = nrs_i_q;
      rd_vld_d = '0;
      for (int k = 0; k < N_RD; k++) begin
         if (rd_en[k]) begin
            if (bank_valid) begin
               nrs_r_d[k]  = bank_r[rd_bank_q][k];
               nrs_i_d[k]  = bank_i[rd_bank_q][k];
               rd_vld_d[k] = 1'b1;
            end else begin
               nrs_r_d[k] = 1'b0;
               nrs_i_d[k] = 1'b0;
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full_q     <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         wr_ptr_q   <= '0;
         overflow_q <= 1'b0;
         nrs_r_q    <= '0;
         nrs_i_q    <= '0;
         rd_vld_q   <= '0;
      end else begin
         full_q     <= full_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         wr_ptr_q   <= wr_ptr_d;
         overflow_q <= overflow_d;
         nrs_r_q    <= nrs_r_d;
         nrs_i_q    <= nrs_i_d;
         rd_vld_q   <= rd_vld_d;
      end
   end

endmodule

// File: doc/nrs_pingpong_buf.md
Name: nrs_pingpong_buf

Overview:
- Double-buffered (ping-pong) store for the NRS Gold-sequence bits c(n) produced by the NRS value generator.
- The generator fills one bank serially while the channel estimator and fine-timing paths read QPSK bit pairs (real, imag) from the other bank.
- Adds N_RD independent registered read ports, an automatic write pointer, bank-swap handshaking, and overflow detection.
- Sits between the c(n) generator and the estimation/timing datapaths.

Parameters:
- DEPTH, 16, bits per bank; power of two, ≥4.
- LINES, $clog2(DEPTH), address width.
- N_RD, 2, number of read ports (port 0 = estimator, port 1 = fine timing).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for c_n.
- c_n  in  1  Gold sequence bit.
- frame_start  in  1  discards any partial fill and clears overflow.
- wr_ready  out  1  fill bank has space.
- overflow  out  1  sticky; a write was attempted while wr_ready=0.
- rd_en  in  N_RD  per-port read request.
- rd_addr  in  N_RD*LINES  packed read addresses; port k uses bits [k*LINES +: LINES].
- rd_release  in  1  consumer finished with the active bank.
- bank_valid  out  1  active read bank holds a complete sequence.
- nrs_r  out  N_RD  real bit per port, registered.
- nrs_i  out  N_RD  imaginary bit per port, registered.
- rd_vld  out  N_RD  per-port read data valid.

Behaviour:
- State: two DEPTH-bit banks, full[1:0], wr_bank, rd_bank, wr_ptr[LINES-1:0].
- Reset (async, rst=0): banks, full, wr_bank, rd_bank, wr_ptr, overflow, nrs_r, nrs_i and rd_vld all go to 0. wr_ready=1, bank_valid=0.
- Occupancy FSM, derived from the full flags:
  - EMPTY (0 full) → ONE when a fill completes.
  - ONE → TWO on a fill completion without a release.
  - ONE → EMPTY on a release without a fill completion.
  - TWO → ONE on a release.
  - Fill completion and release in the same cycle leave occupancy unchanged.
- wr_ready = !full[wr_bank], combinational.
- Write acceptance: wr_en & wr_ready & !frame_start.
  - bank[wr_bank][wr_ptr] <= c_n; wr_ptr <= wr_ptr+1 (wraps).
  - When wr_ptr==DEPTH-1: full[wr_bank] <= 1 and wr_bank toggles.
- wr_en while wr_ready=0: data dropped, overflow <= 1. Nothing else changes.
- frame_start: wr_ptr <= 0 and overflow <= 0.
  - Full banks are untouched.
  - frame_start has priority over a same-cycle wr_en; that write is dropped.
- bank_valid = full[rd_bank], combinational.
- Read, port k, one-cycle latency: if rd_en[k] & bank_valid, then next cycle:
  - nrs_r[k] = bank[rd_bank][{addr[LINES-1:1],0}]
  - nrs_i[k] = bank[rd_bank][{addr[LINES-1:1],1}]
  - rd_vld[k] = 1.
  - The address LSB is ignored, so an odd address returns the same pair as the even address below it.
- rd_en[k] while !bank_valid: next cycle rd_vld[k]=0 and nrs_r[k]=nrs_i[k]=0.
- rd_vld[k] is 0 in any cycle following rd_en[k]=0. nrs_r/nrs_i hold their last value.
- Ports are independent. Same-address reads on both ports are legal.
- rd_release & bank_valid: full[rd_bank] <= 0 and rd_bank toggles.
  - rd_release while !bank_valid is ignored.
- Read and release in the same cycle: the read samples the pre-release bank and its data is returned normally.
- Fill completion and release in the same cycle: both take effect.
  - Write and read can never target the same bank while it is valid, because wr_bank≠rd_bank whenever the read bank is full.
- A fill may start immediately after a completion, with no bubble.

Decomposition:
- Package nrs_pkg: DEPTH default (16), BITS_PER_RE=2, RE_PAIR_IDX offsets (REAL=0, IMAG=1), and an occupancy enum (EMPTY, ONE, TWO) for debug/assertions.
- Sub-module nrs_bank, instantiated twice:
  - one DEPTH-bit register with a write port (we, addr, bit) and a clear;
  - N_RD combinational pair-read outputs.
- Bank select, the output registers and the occupancy FSM live in the top module.

Test Plan:
- Reset → wr_ready=1, bank_valid=0, overflow=0, rd_vld=00. rd_en=11 at any address → rd_vld=00, nrs_r=nrs_i=00.
- Write 0xA5C3 LSB-first (bit n at address n) over 16 wr_en cycles → bank_valid=1 the cycle after the 16th write. rd_en[0], addr 6 → next cycle nrs_r[0]=1, nrs_i[0]=1. rd_en[1], addr 5 (reads 4/5) → nrs_r[1]=0, nrs_i[1]=0.
- Fill a second bank with 0x0F0F, then one extra wr_en → wr_ready=0, overflow=1, both banks unchanged. rd_release → bank_valid stays 1, wr_ready=1. Read addr 4 → r=0, i=0. Read addr 0 → r=1, i=1.
- Occupancy ONE with wr_ptr=15 on bank 1: rd_release and the 16th wr_en in the same cycle → occupancy stays ONE, rd_bank=1, a read of bank 1 returns the new data, wr_bank=0.
- 7 writes, then frame_start (with a simultaneous wr_en) → the write is dropped and wr_ptr=0. 16 more writes of 0xFFFF → bank_valid=1 and every pair reads 1,1.
- Assert rst=0 asynchronously mid-fill, with both ports reading → all outputs 0 immediately. After release, a fresh 16-bit fill behaves as from power-up.
